// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - requester-side load/store/copy controller for the 16x8 data memory
// All outputs are registered; next-state values are built in one combinational block.
module dmem_access_unit #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic                  Req_Valid_i,
    output logic                  Req_Ready_o,
    input  logic [1:0]            Req_Op_i,
    input  logic [ADDR_WIDTH-1:0] Req_Address_i,
    input  logic [ADDR_WIDTH-1:0] Req_Dest_i,
    input  logic [ADDR_WIDTH-1:0] Req_Count_i,
    input  logic [DATA_WIDTH-1:0] Req_Data_i,
    output logic                  Resp_Valid_o,
    output logic [DATA_WIDTH-1:0] Resp_Data_o,
    output logic                  Resp_Error_o,
    output logic                  Mem_Write_Enable_o,
    output logic [ADDR_WIDTH-1:0] Mem_Write_Address_o,
    output logic [ADDR_WIDTH-1:0] Mem_Read_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Data_In_o,
    input  logic [DATA_WIDTH-1:0] Mem_Data_Out_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            lat_q, lat_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        resp_data_d = '0;
        resp_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req_Valid_i && ready_q) begin
                    op_d  = Req_Op_i;
                    src_d = Req_Address_i;
                    dst_d = Req_Dest_i;
                    cnt_d = Req_Count_i;
                    lat_d = '0;
                    case (Req_Op_i)
                        OP_LOAD: begin
                            state_d   = READ;
                            rd_addr_d = Req_Address_i;
                        end
                        OP_STORE: begin
                            state_d   = WRITE;
                            we_d      = 1'b1;
                            wr_addr_d = Req_Address_i;
                            din_d     = Req_Data_i;
                        end
                        OP_COPY: begin
                            if (Req_Count_i == '0) begin
                                state_d = RESP;
                            end else begin
                                state_d   = READ;
                                rd_addr_d = Req_Address_i;
                            end
                        end
                        default: begin
                            state_d    = RESP;
                            resp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            READ: begin
                if (lat_q == LAT_LAST) begin
                    if (op_q == OP_LOAD) begin
                        state_d     = RESP;
                        resp_data_d = Mem_Data_Out_i;
                    end else begin
                        state_d   = WRITE;
                        we_d      = 1'b1;
                        wr_addr_d = dst_q;
                        din_d     = Mem_Data_Out_i;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            WRITE: begin
                if (op_q != OP_COPY) begin
                    state_d = RESP;
                end else if (cnt_q == ADDR_WIDTH'(1)) begin
                    state_d     = RESP;
                    resp_data_d = din_q;
                end else begin
                    // Next copy word: both bases advance and wrap naturally.
                    state_d   = READ;
                    cnt_d     = cnt_q - ADDR_WIDTH'(1);
                    src_d     = src_q + ADDR_WIDTH'(1);
                    dst_d     = dst_q + ADDR_WIDTH'(1);
                    rd_addr_d = src_q + ADDR_WIDTH'(1);
                    lat_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q      <= IDLE;
            op_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            cnt_q        <= '0;
            lat_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            din_q        <= din_d;
        end
    end

    assign Req_Ready_o         = ready_q;
    assign Resp_Valid_o        = resp_valid_q;
    assign Resp_Data_o         = resp_data_q;
    assign Resp_Error_o        = resp_err_q;
    assign Mem_Write_Enable_o  = we_q;
    assign Mem_Write_Address_o = wr_addr_q;
    assign Mem_Read_Address_o  = rd_addr_q;
    assign Mem_Data_In_o       = din_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - random and directed bench for dmem_access_unit at READ_LATENCY 1 and 3
// Two DUTs run the same requests, each against its own memory; a word-level model predicts results.
module tb_dmem_access_unit;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, rst3 = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = '0;
    logic [3:0] req_addr = '0, req_dest = '0, req_count = '0;
    logic [7:0] req_data = '0;

    logic       rdy1, rv1, re1, we1, rdy3, rv3, re3, we3;
    logic [7:0] rd1, di1, do1, rd3, di3, do3;
    logic [3:0] wa1, ra1, wa3, ra3;

    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] refm [16];
    logic [3:0] exp_wa [$];
    logic [7:0] exp_wd [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1)) u_dut1 (
        .Clock_i(clk), .Reset_i(rst1), .Req_Valid_i(req_valid), .Req_Ready_o(rdy1),
        .Req_Op_i(req_op), .Req_Address_i(req_addr), .Req_Dest_i(req_dest),
        .Req_Count_i(req_count), .Req_Data_i(req_data), .Resp_Valid_o(rv1),
        .Resp_Data_o(rd1), .Resp_Error_o(re1), .Mem_Write_Enable_o(we1),
        .Mem_Write_Address_o(wa1), .Mem_Read_Address_o(ra1), .Mem_Data_In_o(di1),
        .Mem_Data_Out_i(do1));

    dmem_access_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(3)) u_dut3 (
        .Clock_i(clk), .Reset_i(rst3), .Req_Valid_i(req_valid), .Req_Ready_o(rdy3),
        .Req_Op_i(req_op), .Req_Address_i(req_addr), .Req_Dest_i(req_dest),
        .Req_Count_i(req_count), .Req_Data_i(req_data), .Resp_Valid_o(rv3),
        .Resp_Data_o(rd3), .Resp_Error_o(re3), .Mem_Write_Enable_o(we3),
        .Mem_Write_Address_o(wa3), .Mem_Read_Address_o(ra3), .Mem_Data_In_o(di3),
        .Mem_Data_Out_i(do3));

    assign do1 = mem1[ra1];
    assign do3 = mem3[ra3];
    always @(posedge clk) begin
        if (we1) mem1[wa1] <= di1;
        if (we3) mem3[wa3] <= di3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [1:0] op, input logic [3:0] cnt, input int lat);
        case (op)
            2'd0:    return lat + 1;
            2'd1:    return 2;
            2'd2:    return (cnt == 0) ? 1 : int'(cnt) * (lat + 1) + 1;
            default: return 1;
        endcase
    endfunction

    task automatic compare_mem();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("mem1[%0d]", i), 32'(mem1[i]), 32'(refm[i]));
            check($sformatf("mem3[%0d]", i), 32'(mem3[i]), 32'(refm[i]));
        end
    endtask

    // Model a copy of n words in ascending order; returns the last word moved.
    task automatic model_copy(input logic [3:0] s, input logic [3:0] d, input int n,
                              output logic [7:0] last);
        logic [3:0] sa, da;
        last = '0;
        for (int i = 0; i < n; i++) begin
            sa = s + 4'(i);
            da = d + 4'(i);
            refm[da] = refm[sa];
            exp_wa.push_back(da);
            exp_wd.push_back(refm[sa]);
            last = refm[sa];
        end
    endtask

    task automatic check_write(input string who, input logic [3:0] wa, input logic [7:0] di,
                               inout int idx);
        if (idx >= exp_wa.size()) begin
            check({who, "_extra_write"}, 32'(1), 32'(0));
        end else begin
            check({who, "_wr_addr"}, 32'(wa), 32'(exp_wa[idx]));
            check({who, "_wr_data"}, 32'(di), 32'(exp_wd[idx]));
        end
        idx++;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d,
                          input logic [3:0] c, input logic [7:0] wd, input bit hold,
                          input bit cmp_mem);
        logic [7:0] exp_data, last;
        int w1, w3, lat1, lat3;
        logic [7:0] got1, got3;
        logic e1, e3;
        bit g1, g3;
        exp_wa.delete();
        exp_wd.delete();
        exp_data = '0;
        case (op)
            2'd0: exp_data = refm[a];
            2'd1: begin
                refm[a] = wd;
                exp_wa.push_back(a);
                exp_wd.push_back(wd);
            end
            2'd2: begin
                model_copy(a, d, int'(c), last);
                exp_data = last;
            end
            default: ;
        endcase
        @(negedge clk);
        req_op = op; req_addr = a; req_dest = d; req_count = c; req_data = wd;
        req_valid = 1'b1;
        check("ready1_idle", 32'(rdy1), 32'(1));
        check("ready3_idle", 32'(rdy3), 32'(1));
        @(posedge clk);
        w1 = 0; w3 = 0; lat1 = 0; lat3 = 0; g1 = 0; g3 = 0;
        got1 = '0; got3 = '0; e1 = 1'b0; e3 = 1'b0;
        for (int cyc = 1; cyc <= 300 && !(g1 && g3); cyc++) begin
            @(negedge clk);
            if (we1) check_write("dut1", wa1, di1, w1);
            if (we3) check_write("dut3", wa3, di3, w3);
            if (rv1) begin
                if (g1) check("dut1_extra_resp", 32'(1), 32'(0));
                g1 = 1; lat1 = cyc; got1 = rd1; e1 = re1;
            end
            if (rv3) begin
                if (g3) check("dut3_extra_resp", 32'(1), 32'(0));
                g3 = 1; lat3 = cyc; got3 = rd3; e3 = re3;
            end
            if (!hold || g1 || g3) begin
                req_valid = 1'b0;
            end else begin
                req_op = 2'($urandom_range(0, 3));
                req_addr = 4'($urandom); req_dest = 4'($urandom);
                req_count = 4'($urandom); req_data = 8'($urandom);
            end
        end
        req_valid = 1'b0;
        check("dut1_latency", 32'(lat1), 32'(exp_latency(op, c, 1)));
        check("dut3_latency", 32'(lat3), 32'(exp_latency(op, c, 3)));
        check("dut1_resp_data", 32'(got1), 32'(exp_data));
        check("dut3_resp_data", 32'(got3), 32'(exp_data));
        check("dut1_resp_err", 32'(e1), 32'(op == 2'd3));
        check("dut3_resp_err", 32'(e3), 32'(op == 2'd3));
        check("dut1_num_writes", 32'(w1), 32'(exp_wa.size()));
        check("dut3_num_writes", 32'(w3), 32'(exp_wa.size()));
        if (cmp_mem) compare_mem();
    endtask

    // Copy of 5 words, each DUT reset while its 2nd write is on the bus.
    task automatic run_abort();
        logic [7:0] last;
        int n1, n3, ph1, ph3, w1, w3;
        bit any_resp;
        exp_wa.delete();
        exp_wd.delete();
        model_copy(4'd0, 4'd8, 2, last);
        @(negedge clk);
        req_op = 2'd2; req_addr = 4'd0; req_dest = 4'd8; req_count = 4'd5;
        req_valid = 1'b1;
        @(posedge clk);
        n1 = 0; n3 = 0; ph1 = 0; ph3 = 0; w1 = 0; w3 = 0; any_resp = 0;
        for (int cyc = 1; cyc <= 200 && !(ph1 == 3 && ph3 == 3); cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rv1 || rv3) any_resp = 1;
            if (we1) begin n1++; check_write("abort1", wa1, di1, w1); end
            if (we3) begin n3++; check_write("abort3", wa3, di3, w3); end
            case (ph1)
                0: if (n1 == 2) begin rst1 = 1'b1; ph1 = 1; end
                1: begin
                    check("abort1_ready_rst", 32'(rdy1), 32'(0));
                    check("abort1_we_rst", 32'(we1), 32'(0));
                    rst1 = 1'b0; ph1 = 2;
                end
                2: begin check("abort1_ready_after", 32'(rdy1), 32'(1)); ph1 = 3; end
                default: ;
            endcase
            case (ph3)
                0: if (n3 == 2) begin rst3 = 1'b1; ph3 = 1; end
                1: begin
                    check("abort3_ready_rst", 32'(rdy3), 32'(0));
                    check("abort3_we_rst", 32'(we3), 32'(0));
                    rst3 = 1'b0; ph3 = 2;
                end
                2: begin check("abort3_ready_after", 32'(rdy3), 32'(1)); ph3 = 3; end
                default: ;
            endcase
        end
        check("abort_done", 32'(ph1 == 3 && ph3 == 3), 32'(1));
        check("abort_no_resp", 32'(any_resp), 32'(0));
        repeat (4) @(negedge clk);
        check("abort_no_late_write", 32'(n1 + n3), 32'(4));
        compare_mem();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready1", 32'(rdy1), 32'(0));
        check("rst_ready3", 32'(rdy3), 32'(0));
        check("rst_outs1", 32'({rv1, re1, we1, rd1, wa1, ra1, di1}), 32'(0));
        check("rst_outs3", 32'({rv3, re3, we3, rd3, wa3, ra3, di3}), 32'(0));
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("ready1_after_rst", 32'(rdy1), 32'(1));
        check("ready3_after_rst", 32'(rdy3), 32'(1));

        for (int i = 0; i < 16; i++) run_op(2'd1, 4'(i), 4'd0, 4'd0, 8'($urandom), 0, 0);
        compare_mem();

        run_op(2'd1, 4'd3, 4'd0, 4'd0, 8'hA5, 0, 1);
        run_op(2'd0, 4'd3, 4'd0, 4'd0, 8'h00, 0, 0);
        run_op(2'd1, 4'd2, 4'd0, 4'd0, 8'h11, 0, 0);
        run_op(2'd1, 4'd3, 4'd0, 4'd0, 8'h22, 0, 0);
        run_op(2'd1, 4'd4, 4'd0, 4'd0, 8'h33, 0, 0);
        run_op(2'd2, 4'd2, 4'd8, 4'd3, 8'h00, 0, 1);
        run_op(2'd2, 4'd14, 4'd0, 4'd4, 8'h00, 0, 1);
        run_op(2'd2, 4'd5, 4'd6, 4'd4, 8'h00, 0, 1);
        run_op(2'd2, 4'd7, 4'd9, 4'd0, 8'h00, 0, 1);
        run_op(2'd3, 4'd7, 4'd9, 4'd3, 8'h5A, 0, 1);
        run_op(2'd0, 4'd10, 4'd0, 4'd0, 8'h00, 1, 1);
        run_op(2'd2, 4'd1, 4'd12, 4'd3, 8'h00, 1, 1);
        run_abort();

        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                   8'($urandom), bit'($urandom_range(0, 1)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
